// File: rtl/weight_streamer_pkg.sv
// Shared definitions for the weight streamer: FSM state encoding,
// byte/address widths and the default bank depth.
package weight_streamer_pkg;

  localparam int BYTE_W        = 8;
  localparam int ADDR_W        = 8;
  localparam int DEPTH_DEFAULT = 256;

  typedef enum logic [1:0] {
    WAIT_BANK = 2'd0,
    LO        = 2'd1,
    HI        = 2'd2,
    DONE      = 2'd3
  } state_e;

endpackage

// File: rtl/weight_streamer_byte_packer.sv
// Byte-to-word assembler: holds the low byte until the matching high byte
// arrives, then presents the full word with a one-cycle valid strobe.
// The word register keeps its value between strobes.
module weight_streamer_byte_packer
  import weight_streamer_pkg::*;
#(
  parameter int N = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [BYTE_W-1:0] data_i,
  input  logic              cap_lo_i,
  input  logic              cap_hi_i,
  input  logic              clr_i,
  output logic [N-1:0]      word_o,
  output logic              word_valid_o
);

  localparam int HI_W = N - BYTE_W;

  logic [BYTE_W-1:0] lo_q, lo_d;
  logic [N-1:0]      word_q, word_d;
  logic              valid_q, valid_d;

  // Capture the low byte, or build the word when the high byte lands
  always_comb begin
    lo_d    = lo_q;
    word_d  = word_q;
    valid_d = cap_hi_i;
    if (clr_i) begin
      lo_d = '0;
    end else if (cap_lo_i) begin
      lo_d = data_i;
    end
    if (cap_hi_i) begin
      word_d = {HI_W'(data_i), lo_q};
    end
  end

  // Assembly registers; reset drops any half-built word
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      lo_q    <= '0;
      word_q  <= '0;
      valid_q <= 1'b0;
    end else begin
      lo_q    <= lo_d;
      word_q  <= word_d;
      valid_q <= valid_d;
    end
  end

  assign word_o       = word_q;
  assign word_valid_o = valid_q;

endmodule

// File: rtl/weight_streamer.sv
// Weight streamer: accepts weight bytes from a host (low byte first),
// assembles N-bit words and writes one bank of DEPTH words at a time into
// a ping-pong SRAM. A bank is only started once the consumer frees it.
module weight_streamer
  import weight_streamer_pkg::*;
#(
  parameter int N     = 16,
  parameter int DEPTH = DEPTH_DEFAULT
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [BYTE_W-1:0] host_data,
  input  logic              host_valid,
  output logic              host_ready,
  input  logic              bank_free,
  input  logic              flush,
  output logic [N-1:0]      weights_in,
  output logic              weights_valid,
  output logic [ADDR_W-1:0] write_addr,
  output logic              bank_sel,
  output logic              bank_done,
  output logic              busy
);

  localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(DEPTH - 1);

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] idx_q, idx_d;
  logic              bank_sel_q, bank_sel_d;
  logic              bank_done_q, bank_done_d;
  logic              last_word;
  logic              cap_lo, cap_hi;

  // The index equals the word being received in HI and the word being
  // strobed, so one comparison serves both the DONE decision and the wrap.
  assign last_word = (idx_q == LAST_IDX);

  // State register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= WAIT_BANK;
    end else begin
      state_q <= state_d;
    end
  end

  // Next state; flush wins over everything and abandons the bank
  always_comb begin
    state_d = state_q;
    if (flush) begin
      state_d = WAIT_BANK;
    end else begin
      case (state_q)
        WAIT_BANK: if (bank_free)  state_d = LO;
        LO:        if (host_valid) state_d = HI;
        HI:        if (host_valid) state_d = last_word ? DONE : LO;
        DONE:      state_d = WAIT_BANK;
        default:   state_d = WAIT_BANK;
      endcase
    end
  end

  // State-decoded outputs; ready depends on state alone, so in LO/HI a
  // handshake reduces to host_valid
  always_comb begin
    host_ready = 1'b0;
    busy       = 1'b1;
    cap_lo     = 1'b0;
    cap_hi     = 1'b0;
    case (state_q)
      WAIT_BANK: busy = 1'b0;
      LO: begin
        host_ready = 1'b1;
        cap_lo     = host_valid & ~flush;
      end
      HI: begin
        host_ready = 1'b1;
        cap_hi     = host_valid & ~flush;
      end
      default: ;
    endcase
  end

  // Word index, bank select toggle and bank-complete pulse
  always_comb begin
    idx_d       = idx_q;
    bank_sel_d  = bank_sel_q;
    bank_done_d = 1'b0;
    if (flush) begin
      idx_d = '0;
    end else begin
      if (weights_valid) begin
        idx_d = last_word ? '0 : idx_q + ADDR_W'(1);
      end
      if (state_q == DONE) begin
        bank_done_d = 1'b1;
        bank_sel_d  = ~bank_sel_q;
      end
    end
  end

  // Bank bookkeeping registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      idx_q       <= '0;
      bank_sel_q  <= 1'b0;
      bank_done_q <= 1'b0;
    end else begin
      idx_q       <= idx_d;
      bank_sel_q  <= bank_sel_d;
      bank_done_q <= bank_done_d;
    end
  end

  weight_streamer_byte_packer #(
    .N (N)
  ) byte_packer (
    .clk          (clk),
    .rst          (rst),
    .data_i       (host_data),
    .cap_lo_i     (cap_lo),
    .cap_hi_i     (cap_hi),
    .clr_i        (flush),
    .word_o       (weights_in),
    .word_valid_o (weights_valid)
  );

  assign write_addr = idx_q;
  assign bank_sel   = bank_sel_q;
  assign bank_done  = bank_done_q;

endmodule

// File: tb/tb_weight_streamer.sv
// Scoreboard bench for weight_streamer. The driver tracks accepted bytes at
// transaction level (byte pairs -> words, DEPTH words -> bank) and queues
// the expected writes; a separate monitor checks every strobe and bank_done.
module tb_weight_streamer;

  localparam int N     = 16;
  localparam int DEPTH = 256;

  logic         clk;
  logic         rst;
  logic [7:0]   host_data;
  logic         host_valid;
  logic         host_ready;
  logic         bank_free;
  logic         flush;
  logic [N-1:0] weights_in;
  logic         weights_valid;
  logic [7:0]   write_addr;
  logic         bank_sel;
  logic         bank_done;
  logic         busy;

  weight_streamer #(
    .N     (N),
    .DEPTH (DEPTH)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .host_data     (host_data),
    .host_valid    (host_valid),
    .host_ready    (host_ready),
    .bank_free     (bank_free),
    .flush         (flush),
    .weights_in    (weights_in),
    .weights_valid (weights_valid),
    .write_addr    (write_addr),
    .bank_sel      (bank_sel),
    .bank_done     (bank_done),
    .busy          (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [N-1:0] data;
    logic [7:0]   addr;
    logic         bank;
  } exp_t;

  exp_t exp_q[$];
  logic done_q[$];

  int checks = 0;
  int errors = 0;

  // Reference model state
  logic       m_has_lo;
  logic [7:0] m_lo;
  int         m_words;
  logic       m_bank;
  logic       rand_free;
  logic       prev_final;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  task automatic model_reset();
    m_has_lo = 1'b0;
    m_lo     = 8'h00;
    m_words  = 0;
    m_bank   = 1'b0;
  endtask

  // One host cycle: apply inputs at the falling edge, decide acceptance
  task automatic drive(input logic v, input logic [7:0] d, input logic f, output logic acc);
    @(negedge clk);
    host_valid = v;
    host_data  = d;
    flush      = f;
    if (rand_free) bank_free = 1'($urandom_range(1));
    acc = v && host_ready && !f;
    if (f) begin
      m_has_lo = 1'b0;
      m_words  = 0;
    end else if (acc) begin
      if (!m_has_lo) begin
        m_lo     = d;
        m_has_lo = 1'b1;
      end else begin
        exp_q.push_back('{data: {d, m_lo}, addr: 8'(m_words), bank: m_bank});
        m_has_lo = 1'b0;
        m_words++;
        if (m_words == DEPTH) begin
          m_words = 0;
          m_bank  = ~m_bank;
          done_q.push_back(m_bank);
        end
      end
    end
  endtask

  task automatic send_byte(input logic [7:0] d, input int pct);
    logic acc;
    int   n;
    acc = 1'b0;
    n   = 0;
    while (!acc && n < 200) begin
      drive(int'($urandom_range(99)) < pct, d, 1'b0, acc);
      n++;
    end
    checks++;
    if (!acc) begin
      errors++;
      $display("FAIL accept_timeout byte=%0h not accepted within 200 cycles", d);
    end
  endtask

  task automatic idle(input int cycles);
    logic acc;
    for (int i = 0; i < cycles; i++) drive(1'b0, 8'h00, 1'b0, acc);
  endtask

  task automatic check_all_zero(input string tag);
    chk({tag, "_host_ready"}, 32'(host_ready), 32'd0);
    chk({tag, "_weights_in"}, 32'(weights_in), 32'd0);
    chk({tag, "_weights_valid"}, 32'(weights_valid), 32'd0);
    chk({tag, "_write_addr"}, 32'(write_addr), 32'd0);
    chk({tag, "_bank_sel"}, 32'(bank_sel), 32'd0);
    chk({tag, "_bank_done"}, 32'(bank_done), 32'd0);
    chk({tag, "_busy"}, 32'(busy), 32'd0);
  endtask

  // Monitor: every strobe must match the head of the expected queue, and
  // bank_done must follow the strobe of the last word by exactly one cycle
  initial begin
    exp_t e;
    logic b;
    prev_final = 1'b0;
    forever begin
      @(negedge clk);
      if (weights_valid) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL strobe_unexpected addr=%0d data=%0h expected no strobe", write_addr, weights_in);
        end else begin
          e = exp_q.pop_front();
          chk("wdata", 32'(weights_in), 32'(e.data));
          chk("waddr", 32'(write_addr), 32'(e.addr));
          chk("wbank", 32'(bank_sel), 32'(e.bank));
        end
      end
      if (bank_done) begin
        chk("done_after_last_word", 32'(prev_final), 32'd1);
        if (done_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL done_unexpected bank_sel=%0d expected no bank_done", bank_sel);
        end else begin
          b = done_q.pop_front();
          chk("done_bank_sel", 32'(bank_sel), 32'(b));
        end
      end
      prev_final = weights_valid && (write_addr == 8'(DEPTH - 1));
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    logic       acc;
    logic [7:0] pair [2];
    int         k;
    logic       tog;

    rst        = 1'b0;
    host_valid = 1'b0;
    host_data  = 8'h00;
    bank_free  = 1'b0;
    flush      = 1'b0;
    rand_free  = 1'b0;
    model_reset();

    repeat (2) @(negedge clk);
    check_all_zero("reset");
    rst       = 1'b1;
    bank_free = 1'b1;

    // Bank 0: bytes 0x00..0xFF twice, valid held high
    for (int i = 0; i < 512; i++) send_byte(8'(i), 100);
    bank_free = 1'b0;

    // Consumer still busy with the next bank: streamer must hold off
    for (int i = 0; i < 20; i++) begin
      drive(1'b1, 8'hA5, 1'b0, acc);
      chk("ready_blocked", 32'(host_ready), 32'd0);
    end
    chk("bank_sel_after_bank0", 32'(bank_sel), 32'd1);
    chk("busy_waiting", 32'(busy), 32'd0);
    bank_free = 1'b1;
    chk("ready_same_cycle_free", 32'(host_ready), 32'd0);
    drive(1'b0, 8'h00, 1'b0, acc);
    chk("ready_after_free", 32'(host_ready), 32'd1);
    chk("busy_loading", 32'(busy), 32'd1);

    // Bank 1: random bytes, sparse valid, bank_free wandering mid-load
    for (int i = 0; i < 512; i++) begin
      send_byte(8'($urandom_range(255)), 70);
      if (i == 0) rand_free = 1'b1;
    end
    rand_free = 1'b0;
    bank_free = 1'b0;
    idle(10);
    chk("bank_sel_back_to_0", 32'(bank_sel), 32'd0);
    chk("busy_after_bank1", 32'(busy), 32'd0);

    // Valid toggling every cycle with bytes 0x34, 0x12
    bank_free = 1'b1;
    pair[0] = 8'h34;
    pair[1] = 8'h12;
    k   = 0;
    tog = 1'b1;
    for (int c = 0; c < 20 && k < 2; c++) begin
      drive(tog, pair[k], 1'b0, acc);
      if (acc) k++;
      tog = ~tog;
    end
    chk("toggle_pair_accepted", 32'(k), 32'd2);
    idle(4);
    chk("hold_word", 32'(weights_in), 32'h1234);
    chk("addr_after_first_word", 32'(write_addr), 32'd1);

    // Words 1..9, low byte of word 10, then flush on its high byte
    for (int i = 0; i < 18; i++) send_byte(8'($urandom_range(255)), 90);
    send_byte(8'($urandom_range(255)), 100);
    drive(1'b1, 8'hEE, 1'b1, acc);
    drive(1'b0, 8'h00, 1'b0, acc);
    chk("bank_sel_after_flush", 32'(bank_sel), 32'd0);
    chk("addr_after_flush", 32'(write_addr), 32'd0);

    // 100 words from address 0, plus a dangling low byte
    for (int i = 0; i < 200; i++) send_byte(8'($urandom_range(255)), 80);
    send_byte(8'h77, 100);
    idle(3);
    chk("drained_before_reset", 32'(exp_q.size()), 32'd0);

    // Asynchronous reset mid-bank
    rst = 1'b0;
    #1;
    check_all_zero("midreset");
    model_reset();
    @(negedge clk);
    rst = 1'b1;

    for (int i = 0; i < 8; i++) send_byte(8'($urandom_range(255)), 100);
    idle(6);
    chk("exp_queue_drained", 32'(exp_q.size()), 32'd0);
    chk("done_queue_drained", 32'(done_q.size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/weight_streamer.md
WEIGHT_STREAMER -- requirements
Module: weight_streamer

Interface
REQ-001 SHALL have parameter N, default 16, weight word width (even, multiple of 8 not required; 2 bytes per word).
REQ-002 SHALL have parameter DEPTH, default 256, words per bank; write_addr width is 8.
REQ-003 SHALL have port clk  input  1  single clock, rising edge.
REQ-004 SHALL have port rst  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port host_data  input  8  weight byte from host, low byte first.
REQ-006 SHALL have port host_valid  input  1  host byte valid.
REQ-007 SHALL have port host_ready  output  1  streamer accepts byte; transfer when valid&ready on clk edge.
REQ-008 SHALL have port bank_free  input  1  level, consumer no longer reads the bank selected by bank_sel.
REQ-009 SHALL have port flush  input  1  synchronous abort of current bank load.
REQ-010 SHALL have port weights_in  output  N  assembled weight word toward SRAM write side.
REQ-011 SHALL have port weights_valid  output  1  one-cycle write strobe for weights_in.
REQ-012 SHALL have port write_addr  output  8  word address of weights_in.
REQ-013 SHALL have port bank_sel  output  1  bank currently being written.
REQ-014 SHALL have port bank_done  output  1  one-cycle pulse, bank fully written.
REQ-015 SHALL have port busy  output  1  high in any state except WAIT_BANK.

Function
REQ-016 SHALL implement FSM states WAIT_BANK, LO, HI, DONE.
REQ-017 WAIT_BANK: host_ready=0; go to LO the cycle after bank_free sampled 1.
REQ-018 LO: host_ready=1; on handshake capture byte into word[7:0], go to HI; no handshake, stay.
REQ-019 HI: host_ready=1; on handshake capture byte into word[N-1:8], go to LO (or DONE if word index = DEPTH-1).
REQ-020 weights_valid SHALL pulse exactly the cycle after the HI handshake, with weights_in = assembled word and write_addr = word index.
REQ-021 Word index SHALL start at 0 per bank, increment after each weights_valid, wrap DEPTH-1 -> 0.
REQ-022 DONE: lasts one cycle, coincides with weights_valid of word DEPTH-1; next cycle bank_done=1 for one cycle, bank_sel toggles, state WAIT_BANK.
REQ-023 host_ready SHALL be combinational from state only, never from host_valid.
REQ-024 flush=1 SHALL override any handshake that cycle: byte discarded, no weights_valid next cycle, index=0, state WAIT_BANK, bank_sel unchanged, no bank_done.
REQ-025 bank_free deassertion mid-load SHALL be ignored; it is only sampled in WAIT_BANK.
REQ-026 weights_in SHALL hold its last value when weights_valid=0.

Reset
REQ-027 rst=0 SHALL asynchronously force: state WAIT_BANK, host_ready 0, weights_in 0, weights_valid 0, write_addr 0, bank_sel 0, bank_done 0, busy 0, partial byte cleared.
REQ-028 Reset mid-bank SHALL discard the partial bank; after release, load restarts at index 0, bank 0.

Structure
REQ-029 Shared package SHALL hold state encoding, DEPTH default, byte width constant.
REQ-030 Byte-to-word assembly SHALL be one sub-module, byte_packer (capture LO/HI, output word + word_valid).

Verification
REQ-031 bank_free=1, host streams 512 bytes 0x00..0xFF twice, valid always high -> 256 weights_valid pulses, word k = {byte 2k+1, byte 2k}, write_addr 0..255, bank_done one cycle after addr 255, bank_sel 0->1.
REQ-032 bank_free=0 after first bank -> host_ready stays 0, no weights_valid; raise bank_free -> host_ready=1 next cycle, second bank written with bank_sel=1, then bank_sel returns 0.
REQ-033 host_valid toggling 1/0 every cycle, bytes 0x34,0x12 -> weights_in=0x1234 at addr 0, single strobe, no duplicate capture.
REQ-034 flush asserted together with HI handshake at word 10 -> no strobe for word 10, next byte pair lands at addr 0, bank_sel unchanged, no bank_done.
REQ-035 rst low for 1 cycle after 100 words -> all outputs 0 immediately; after release, first strobe has addr 0, bank_sel 0.
